// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, segment bit
// positions and the pending-buffer state encoding.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry k is the {g,f,e,d,c,b,a} pattern for code k; hex letters are A,b,C,d,E,F.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load port of the scan driver: a display word plus decimal points offered
// with a valid/ready handshake.
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic                    load_valid;
  logic [4*N_DIGITS-1:0]   load_data;
  logic [N_DIGITS-1:0]     load_dp;
  logic                    load_ready;

  modport master (output load_valid, load_data, load_dp, input load_ready);
  modport slave  (input load_valid, load_data, load_dp, output load_ready);
endinterface

// File: rtl/seg7_glyph.sv
// Combinational 4-bit code to seven-segment glyph decoder.
import seg7_pkg::*;

module seg7_glyph (
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_TAB[code];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver with a one-deep pending word that is
// promoted only at frame end. Optional macro SEG7_LEAD_ZERO_BLANK_EN.
//
// state      | meaning
// PEND_EMPTY | no word waiting, load_ready high
// PEND_FULL  | word waiting for the next frame end, load_ready low
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   ld,
  input  logic                blank,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] digit_en
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] active_word;
  logic [N_DIGITS-1:0]   active_dp;
  logic [4*N_DIGITS-1:0] pend_word;
  logic [N_DIGITS-1:0]   pend_dp;
  pend_state_e           pend_state;
  pend_state_e           pend_next;

  logic       div_wrap;
  logic       frame_end;
  logic       xfer;
  logic       promote;
  logic [3:0] cur_code;
  logic [6:0] cur_glyph;
  logic [6:0] seg_lit;

  assign div_wrap  = (div_cnt == LAST_DIV);
  assign frame_end = div_wrap && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_state <= PEND_EMPTY;
    end else begin
      pend_state <= pend_next;
    end
  end

  always_comb begin
    pend_next = pend_state;
    case (pend_state)
      PEND_EMPTY: if (ld.load_valid) pend_next = PEND_FULL;
      PEND_FULL:  if (frame_end)     pend_next = PEND_EMPTY;
      default:    pend_next = PEND_EMPTY;
    endcase
  end

  // load_ready depends on state only, so a master may wait on it combinationally.
  always_comb begin
    ld.load_ready = (pend_state == PEND_EMPTY);
    xfer          = ld.load_valid && (pend_state == PEND_EMPTY);
    promote       = frame_end && (pend_state == PEND_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      active_word <= '0;
      active_dp   <= '0;
      pend_word   <= '0;
      pend_dp     <= '0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        idx     <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (xfer) begin
        pend_word <= ld.load_data;
        pend_dp   <= ld.load_dp;
      end
      if (promote) begin
        active_word <= pend_word;
        active_dp   <= pend_dp;
      end
    end
  end

  assign cur_code = active_word[4*idx +: 4];

  seg7_glyph u_glyph (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lead_zero;
  logic                above_zero;

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin
    lead_zero  = '0;
    above_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      above_zero   = above_zero && (active_word[4*k +: 4] == 4'h0);
      lead_zero[k] = above_zero;
    end
  end

  assign seg_lit = lead_zero[idx] ? 7'h00 : cur_glyph;
`else
  assign seg_lit = cur_glyph;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg      <= '0;
      dp       <= 1'b0;
      digit_en <= '0;
    end else if (blank) begin
      seg      <= '0;
      dp       <= 1'b0;
      digit_en <= '0;
    end else begin
      seg      <= seg_lit;
      dp       <= active_dp[idx];
      digit_en <= N_DIGITS'(1) << idx;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each digit stays lit, >=2.
REQ-003 Port clk input 1: the single clock; all state on rising edge.
REQ-004 Port rst input 1: reset, asynchronous, active-high.
REQ-005 Port load_valid input 1: new display word offered.
REQ-006 Port load_data input 4*N_DIGITS: nibble k = code of digit k; digit 0 = least significant.
REQ-007 Port load_dp input N_DIGITS: bit k = decimal point of digit k.
REQ-008 Port load_ready output 1: pending buffer empty, word will be accepted.
REQ-009 Port blank input 1: force display dark.
REQ-010 Port seg output 7: {g,f,e,d,c,b,a}, active-high.
REQ-011 Port dp output 1: decimal point of the lit digit, active-high.
REQ-012 Port digit_en output N_DIGITS: one-hot lit-digit select, active-high.

Function
REQ-013 Divider div_cnt SHALL count 0..SCAN_DIV-1 and wrap; index idx SHALL advance by 1 on each wrap, wrapping N_DIGITS-1 -> 0.
REQ-014 Frame end SHALL be the cycle with div_cnt==SCAN_DIV-1 and idx==N_DIGITS-1.
REQ-015 Glyphs: 0..9 decimal (0=0x3F, 1=0x06, 8=0x7F, 9=0x6F); 10..15 hex A,b,C,d,E,F (0x77,0x7C,0x39,0x5E,0x79,0x71).
REQ-016 Handshake: transfer when load_valid && load_ready; word captured into pending register; load_ready = !pending_full (combinational from state only, not from load_valid).
REQ-017 At frame end with pending_full, pending SHALL copy to active and pending_full clear; display never changes mid-frame.
REQ-018 Transfer in the frame-end cycle while pending empty: word goes to pending, reaches active at the next frame end.
REQ-019 load_valid while load_ready=0: ignored, no state change.
REQ-020 seg, dp, digit_en SHALL be registered: they show active digit idx with one cycle latency.
REQ-021 blank=1 SHALL drive seg=0, dp=0, digit_en=0 from the next cycle; scanning and handshake continue unaffected.

Reset
REQ-022 rst SHALL asynchronously clear div_cnt, idx, active word, active dp, pending_full; seg=0, dp=0, digit_en=0, load_ready=1.
REQ-023 Reset mid-frame SHALL discard any pending word; first cycle after release latches digit 0 (seg=0x3F, digit_en=1) on the following edge.

Configuration
REQ-024 Macro SEG7_LEAD_ZERO_BLANK_EN defined: digits above the most significant nonzero digit whose code is 0 SHALL show seg=0 (dp still shown); digit 0 never blanked.
REQ-025 Macro undefined: every digit decoded per REQ-015, no suppression logic present.

Structure
REQ-026 Package seg7_pkg SHALL hold the 16-entry glyph constant table and segment-bit index constants.
REQ-027 Sub-module seg7_glyph SHALL be the combinational 4-bit code -> 7-bit glyph decoder; one instance.

Verification (N_DIGITS=4, SCAN_DIV=4)
REQ-028 Reset, load 0x1234 dp=0000 -> after first frame end digit_en cycles 0001,0010,0100,1000 showing 0x66,0x4F,0x5B,0x06, 4 cycles each.
REQ-029 Load 0xABCD then 0xEF01 back-to-back -> second load_ready=0 until frame end, 0xEF01 displayed one frame after 0xABCD.
REQ-030 load_valid asserted exactly in frame-end cycle, pending empty -> word displayed after the next frame end, not this one.
REQ-031 blank=1 for 6 cycles mid-digit -> seg/dp/digit_en=0 for 6 cycles, idx sequence unbroken on release.
REQ-032 With SEG7_LEAD_ZERO_BLANK_EN, load 0x0040 dp=0100 -> digit3 seg=0, digit2 seg=0 dp=1, digit1 0x66, digit0 0x3F; 0x0000 -> only digit0 lit 0x3F.
REQ-033 rst pulse mid-frame with pending word -> outputs 0 asynchronously, load_ready=1, display restarts at digit 0 with value 0.
